key_step_conditioner: RTL and testbench



---
 rtl/key_step_pkg.sv | 20 ++
 rtl/key_debounce.sv | 73 +++++++
 rtl/key_step_conditioner.sv | 137 +++++++++++++
 tb/tb_key_step_conditioner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_step_pkg.sv
// Shared types and timing defaults for the pushbutton conditioner and step clock generator.
//   step_state_e         : step FSM state encoding (3 bits)
//   DEBOUNCE_50MHZ_20MS  : 20 ms of stable input at 50 MHz
//   STEP_HIGH_DEFAULT    : step_clk high time / minimum gap, in CLOCK_50 cycles
//   RUN_DIV_DEFAULT      : free-run half-period (0.5 s at 50 MHz)
package key_step_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStepHi  = 3'd1,
    StStepGap = 3'd2,
    StRunHi   = 3'd3,
    StRunLo   = 3'd4
  } step_state_e;

  localparam int unsigned DEBOUNCE_50MHZ_20MS = 1000000;
  localparam int unsigned STEP_HIGH_DEFAULT   = 25;
  localparam int unsigned RUN_DIV_DEFAULT     = 25000000;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, stability counter, debounced level and
// one-cycle press/release pulses.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   key_ni     : raw pushbutton, active-low, asynchronous
//   level_o    : debounced level, 1 = pressed
//   press_o    : one-cycle pulse in the cycle level_o rises
//   release_o  : one-cycle pulse in the cycle level_o falls
module key_debounce
  import key_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  // Synchronizer carries the raw active-low value so its reset state means "released".
  logic [1:0]      sync_q;
  logic            sample;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  assign sample = ~sync_q[1];

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample == level_q) begin
      // Any bounce back to the accepted level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d   = sample;
      cnt_d     = '0;
      press_d   = sample;
      release_d = ~sample;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_ni};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_step_conditioner.sv
// DE2 pushbutton front end for the system core: debounces every key and generates the
// core clock, either one fixed-width pulse per key 0 press or a free-running divided clock.
//   CLOCK_50    : 50 MHz board clock, the only clock
//   SYS_rst     : asynchronous active-low reset
//   KEY_n       : raw active-low pushbuttons
//   run_en      : free-run select (slide switch, asynchronous)
//   key_level   : debounced key state, 1 = pressed
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   step_clk    : clock to the core, straight from a flop
//   step_busy   : step FSM not idle
module key_step_conditioner
  import key_step_pkg::*;
#(
  parameter int unsigned NUM_KEYS         = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_50MHZ_20MS,
  parameter int unsigned STEP_HIGH_CYCLES = STEP_HIGH_DEFAULT,
  parameter int unsigned RUN_DIV          = RUN_DIV_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                SYS_rst,
  input  logic [NUM_KEYS-1:0] KEY_n,
  input  logic                run_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                step_clk,
  output logic                step_busy
);

  localparam int unsigned StepCntW = $clog2(STEP_HIGH_CYCLES) + 1;
  localparam int unsigned DivCntW  = $clog2(RUN_DIV) + 1;
  localparam logic [StepCntW-1:0] StepLast = StepCntW'(STEP_HIGH_CYCLES - 1);
  localparam logic [DivCntW-1:0]  DivLast  = DivCntW'(RUN_DIV - 1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i    (CLOCK_50),
      .rst_ni   (SYS_rst),
      .key_ni   (KEY_n[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g])
    );
  end

  logic [1:0]          run_sync_q;
  logic                run_s;
  step_state_e         state_q, state_d;
  logic [StepCntW-1:0] step_cnt_q, step_cnt_d;
  logic [DivCntW-1:0]  div_cnt_q, div_cnt_d;
  logic                step_clk_q, step_clk_d;

  assign run_s = run_sync_q[1];

  // Counters default to zero so every state change starts its phase from a clean count.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = '0;
    div_cnt_d  = '0;
    step_clk_d = step_clk_q;
    case (state_q)
      StIdle: begin
        step_clk_d = 1'b0;
        if (run_s) begin
          state_d    = StRunHi;
          step_clk_d = 1'b1;
        end else if (key_press[0]) begin
          state_d    = StStepHi;
          step_clk_d = 1'b1;
        end
      end
      StStepHi: begin
        if (step_cnt_q == StepLast) begin
          state_d    = StStepGap;
          step_clk_d = 1'b0;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      StStepGap: begin
        if (step_cnt_q == StepLast) begin
          state_d = StIdle;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      StRunHi: begin
        // The high phase always runs to full length, even if run_s has dropped.
        if (div_cnt_q == DivLast) begin
          state_d    = StRunLo;
          step_clk_d = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StRunLo: begin
        if (div_cnt_q == DivLast) begin
          if (run_s) begin
            state_d    = StRunHi;
            step_clk_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        step_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge SYS_rst) begin
    if (!SYS_rst) begin
      run_sync_q <= 2'b00;
      state_q    <= StIdle;
      step_cnt_q <= '0;
      div_cnt_q  <= '0;
      step_clk_q <= 1'b0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_en};
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      div_cnt_q  <= div_cnt_d;
      step_clk_q <= step_clk_d;
    end
  end

  assign step_clk  = step_clk_q;
  assign step_busy = (state_q != StIdle);

endmodule

// File: tb/tb_key_step_conditioner.sv
// Self-checking bench for key_step_conditioner with short timing parameters.
module tb_key_step_conditioner;

  localparam int unsigned NK = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned R  = 6;

  logic          CLOCK_50;
  logic          SYS_rst;
  logic [NK-1:0] KEY_n;
  logic          run_en;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          step_clk;
  logic          step_busy;

  key_step_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .STEP_HIGH_CYCLES(H),
    .RUN_DIV         (R)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .SYS_rst    (SYS_rst),
    .KEY_n      (KEY_n),
    .run_en     (run_en),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .step_clk   (step_clk),
    .step_busy  (step_busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pressed-history window per key, and a queue of planned
  // {step_clk, step_busy} output values for the step/run generator.
  logic [NK-1:0] hist [0:D+1];
  logic          run_hist [0:2];
  logic [NK-1:0] m_level, m_press, m_release;
  logic          m_clk, m_busy;
  logic [1:0]    plan [$];
  bit            last_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= D + 1; i++) hist[i] = '0;
    for (int i = 0; i < 3; i++) run_hist[i] = 1'b0;
    m_level = '0; m_press = '0; m_release = '0;
    m_clk = 1'b0; m_busy = 1'b0;
    plan.delete();
    last_run = 1'b0;
  endtask

  task automatic model_edge();
    logic press0_prev, run_s, v, same;
    logic [1:0] o;
    for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ~KEY_n;
    run_hist[2] = run_hist[1]; run_hist[1] = run_hist[0]; run_hist[0] = run_en;
    press0_prev = m_press[0];
    run_s = run_hist[2];
    if (plan.size() == 0) begin
      if (run_s) begin
        for (int i = 0; i < R; i++) plan.push_back(2'b11);
        for (int i = 0; i < R; i++) plan.push_back(2'b01);
        last_run = 1'b1;
      end else begin
        if (!last_run && press0_prev) begin
          for (int i = 0; i < H; i++) plan.push_back(2'b11);
          for (int i = 0; i < H; i++) plan.push_back(2'b01);
          plan.push_back(2'b00);
        end
        last_run = 1'b0;
      end
    end
    o = (plan.size() != 0) ? plan.pop_front() : 2'b00;
    m_clk = o[1]; m_busy = o[0];
    // A key level is accepted once D consecutive synchronized samples disagree with it.
    for (int k = 0; k < NK; k++) begin
      v = hist[2][k];
      same = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[j][k] !== v) same = 1'b0;
      m_press[k] = 1'b0; m_release[k] = 1'b0;
      if (same && v != m_level[k]) begin
        m_level[k] = v; m_press[k] = v; m_release[k] = ~v;
      end
    end
  endtask

  task automatic compare_all();
    check("key_level",   32'(key_level),   32'(m_level));
    check("key_press",   32'(key_press),   32'(m_press));
    check("key_release", 32'(key_release), 32'(m_release));
    check("step_clk",    32'(step_clk),    32'(m_clk));
    check("step_busy",   32'(step_busy),   32'(m_busy));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (SYS_rst) model_edge(); else model_reset();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rise(input string tag, input int lim);
    logic p;
    bit found = 0;
    for (int i = 0; i < lim; i++) begin
      p = step_clk;
      tick();
      if (step_clk === 1'b1 && p === 1'b0) begin
        found = 1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Length of the current step_clk phase at level lvl, counting the present cycle.
  task automatic measure_phase(input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_clk !== lvl || step_busy !== 1'b1) break;
      n++;
    end
  endtask

  task automatic count_rises(input int n, output int rises);
    logic p;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      p = step_clk;
      tick();
      if (step_clk === 1'b1 && p === 1'b0) rises++;
    end
  endtask

  initial begin
    int lat, hi, lo, rises, pulses, dur;

    // Reset with every key held down.
    SYS_rst = 1'b0; KEY_n = '0; run_en = 1'b0;
    model_reset();
    #1;
    compare_all();
    ticks(3);
    SYS_rst = 1'b1;
    lat = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (key_press === 4'hF) pulses++;
      if (key_level[0] === 1'b1) break;
    end
    check("reset_release_latency", 32'(lat), 32'd10);
    check("reset_press_all_keys", 32'(pulses), 32'd1);
    ticks(12);
    KEY_n = '1;
    ticks(14);

    // Bounce on key 0: eleven 3-cycle segments, final segment held pressed.
    pulses = 0;
    for (int s = 0; s < 11; s++) begin
      KEY_n[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
      if (s < 10) begin
        for (int i = 0; i < 3; i++) begin
          tick();
          if (key_press[0] === 1'b1) pulses++;
        end
      end
    end
    check("bounce_no_early_press", 32'(pulses), 32'd0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (key_press[0] === 1'b1) pulses++;
      if (key_level[0] === 1'b1) break;
    end
    check("bounce_latency", 32'(lat), 32'd10);
    ticks(12);
    check("bounce_single_press", 32'(pulses), 32'd1);
    KEY_n = '1;
    ticks(24);

    // Single step from a clean press.
    KEY_n[0] = 1'b0;
    wait_rise("step_rise", 30);
    measure_phase(1'b1, hi);
    check("step_high_len", 32'(hi), 32'(H));
    measure_phase(1'b0, lo);
    check("step_gap_len", 32'(lo), 32'(H));
    check("step_busy_done", 32'(step_busy), 32'd0);
    count_rises(20, rises);
    check("step_one_per_press", 32'(rises), 32'd0);
    KEY_n = '1;
    ticks(14);

    // Free run, with keys pressed meanwhile.
    run_en = 1'b1;
    KEY_n = 4'b0000;
    wait_rise("run_rise", 10);
    measure_phase(1'b1, hi);
    check("run_high_len", 32'(hi), 32'(R));
    measure_phase(1'b0, lo);
    check("run_low_len", 32'(lo), 32'(R));
    ticks(20);
    KEY_n = '1;
    ticks(20);

    // Run exit one cycle into a high phase.
    wait_rise("run_exit_rise", 20);
    run_en = 1'b0;
    measure_phase(1'b1, hi);
    check("run_exit_high_len", 32'(hi), 32'(R));
    measure_phase(1'b0, lo);
    check("run_exit_low_len", 32'(lo), 32'(R));
    check("run_exit_idle", 32'(step_busy), 32'd0);
    ticks(10);

    // Asynchronous reset during a step pulse.
    KEY_n[0] = 1'b0;
    wait_rise("rst_mid_rise", 30);
    tick();
    #2;
    SYS_rst = 1'b0;
    #1;
    model_reset();
    check("rst_mid_step_clk", 32'(step_clk), 32'd0);
    compare_all();
    KEY_n = '1;
    ticks(3);
    SYS_rst = 1'b1;
    count_rises(25, rises);
    check("rst_no_glitch_back", 32'(rises), 32'd0);

    // Randomized key and run_en activity against the model.
    for (int seg = 0; seg < 250; seg++) begin
      KEY_n = NK'($urandom);
      if ($urandom_range(0, 7) == 0) run_en = ~run_en;
      dur = $urandom_range(1, 24);
      ticks(dur);
    end
    run_en = 1'b0;
    KEY_n = '1;
    ticks(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
